bcd_down_timer: RTL and testbench
=================================

# bcd_down_timer

Multi-digit BCD down-counter that is loaded with a start value and counts down to zero one step per enabled clock. It signals arrival at zero with a single-cycle `done` pulse. It is the count-down counterpart of the team's BCD up-counter. It drives the same seven-segment/display path and provides countdown timing for the lab exercises.

## Interface
- `DIGITS`, default 2: number of BCD digits; must be 1..4.
- `clock`, in, 1: rising-edge clock.
- `reset`, in, 1: asynchronous, active-low reset.
- `load`, in, 1: load request, sampled on the rising edge.
- `load_value`, in, 4*DIGITS: start value. Digit 0 is bits [3:0], the least significant digit.
- `enable`, in, 1: decrement request, sampled on the rising edge.
- `count`, out, 4*DIGITS: current value, registered and always valid BCD.
- `zero`, out, 1: high when `count` is all zeros. Combinational from the `count` register.
- `done`, out, 1: registered one-cycle pulse on the edge where a decrement reaches zero.
- `load_error`, out, 1: registered one-cycle pulse when a load is rejected.

## Operation
- Reset (asynchronous, active-low):
  - `count` = 0, `zero` = 1, `done` = 0, `load_error` = 0.
  - Reload register = 0 (macro builds only).
- Priority per edge: `load` > `enable`. When both are high, the load wins and no decrement happens that cycle.
- Load:
  - Every nibble of `load_value` ≤ 9: `count` ← `load_value`, `done` ← 0, `load_error` ← 0.
  - Any nibble > 9: `count` is unchanged and `load_error` pulses 1 for one cycle.
  - Loading 0 is legal. It gives `zero` = 1 and does not produce a `done` pulse.
- Decrement (`enable`=1, `load`=0, `count` ≠ 0):
  - Digit 0 decrements.
  - A digit at 0 with a borrow-in wraps to 9 and borrows from the next digit.
  - Borrow ripples within the same cycle. Example: 100 → 099.
- Zero:
  - A decrement that lands on 0 sets `done` = 1 for exactly that one cycle.
  - `enable` while `count` = 0 in the base build: `count` holds at 0, `done` stays 0, and no wrap to 99 occurs.
- `done` and `load_error` are 0 in every cycle where their condition does not hold.
- Non-BCD values can never be held in `count`, because rejected loads are filtered.
- Reset mid-countdown aborts immediately (asynchronously) to the reset values.

## Timing
- Load latency: 1 edge. `count` shows `load_value` after the edge where `load`=1.
- Decrement latency: 1 edge per step.
- A load of N followed by continuous `enable`:
  - `done` is high in the cycle after the N-th enabled edge.
  - `count` reads 0 in that same cycle.
- `zero` follows `count` with no additional delay.
- `load_error` is high for the cycle following the offending edge.

## Configuration
- Macro: `BCD_TIMER_AUTO_RELOAD_EN`.
- Defined:
  - Every accepted load also writes a reload register.
  - `enable` with `count` = 0 and a nonzero reload register sets `count` ← reload register on that edge. No `done` is generated for the reload itself.
  - With continuous `enable`, the period is N+1 cycles per `done` pulse.
  - A reload register of 0 behaves like the base build.
- Undefined: no reload register exists, and the counter stops at 0 as described in Operation.

## Structure
- Shared package `bcd_pkg` holds:
  - the `bcd_digit_t` 4-bit typedef;
  - constants `BCD_MAX` = 4'd9 and `BCD_ZERO` = 4'd0;
  - the `bcd_valid` function (nibble ≤ 9).
- Sub-module `bcd_down_digit`, instantiated `DIGITS` times in a generate loop:
  - Ports: digit in, borrow_in in, digit out, borrow_out out.
  - Purely combinational wrap-from-0-to-9 logic.
- The top level holds the registers, the load validation and the done/error logic.

## Test plan
- Reset: assert `reset`=0 mid-operation at count 37 → `count`=00, `zero`=1, `done`=0 immediately, without waiting for a clock edge.
- Full countdown: load 25, then `enable` for 25 edges → `count` reaches 00, `done` is high for exactly one cycle, `zero`=1. A further `enable` leaves `count` at 00 with no new `done` pulse.
- Borrow: load 10, one `enable` → 09. With `DIGITS`=3, load 100, one `enable` → 099.
- Invalid load: `count`=42, load 3A → `load_error` pulses one cycle and `count` stays 42. Then load 39 → accepted, `load_error`=0.
- Simultaneous events: `load`=1 with value 07 and `enable`=1 at `count`=01 → `count`=07 and no `done` pulse.
- Auto-reload (macro defined): load 03, continuous `enable` → sequence 03, 02, 01, 00 (with `done`), 03, 02, … giving a `done` pulse every 4 cycles.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared BCD types, digit constants and the nibble validity helper
// used by the BCD counter family.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX  = 4'd9;
  localparam bcd_digit_t BCD_ZERO = 4'd0;

  function automatic logic bcd_valid(input bcd_digit_t value);
    return (value <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD digit of a ripple down-counter: subtracts the incoming borrow,
// wrapping 0 to 9 and passing the borrow on to the next digit.
module bcd_down_digit
  import bcd_pkg::*;
(
  input  bcd_digit_t digit,
  input  logic       borrow_in,
  output bcd_digit_t result,
  output logic       borrow_out
);

  always_comb begin
    result     = digit;
    borrow_out = 1'b0;
    if (borrow_in) begin
      if (digit == BCD_ZERO) begin
        result     = BCD_MAX;
        borrow_out = 1'b1;
      end else begin
        result = digit - 4'd1;
      end
    end
  end

endmodule

// File: rtl/bcd_down_timer.sv
// Multi-digit loadable BCD down-counter with done/load_error pulses.
// Define BCD_TIMER_AUTO_RELOAD_EN to reload the last accepted value at zero.
module bcd_down_timer
  import bcd_pkg::*;
#(
  parameter int DIGITS = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_value,
  input  logic                enable,
  output logic [4*DIGITS-1:0] count,
  output logic                zero,
  output logic                done,
  output logic                load_error
);

  localparam int W = 4 * DIGITS;

  logic [W-1:0]    dec_value;
  logic [DIGITS:0] borrow;
  logic            load_ok;
  logic            underflow;

  // Borrow ripples from digit 0 upward; a borrow out of the top digit
  // means the counter was already at zero.
  assign borrow[0] = 1'b1;
  assign underflow = borrow[DIGITS];

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_down_digit u_digit (
      .digit      (count[4*i +: 4]),
      .borrow_in  (borrow[i]),
      .result     (dec_value[4*i +: 4]),
      .borrow_out (borrow[i+1])
    );
  end

  always_comb begin
    load_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (!bcd_valid(load_value[4*i +: 4])) load_ok = 1'b0;
    end
  end

  assign zero = (count == '0);

`ifdef BCD_TIMER_AUTO_RELOAD_EN
  logic [W-1:0] reload;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count      <= '0;
      reload     <= '0;
      done       <= 1'b0;
      load_error <= 1'b0;
    end else begin
      done       <= 1'b0;
      load_error <= 1'b0;
      if (load) begin
        if (load_ok) begin
          count  <= load_value;
          reload <= load_value;
        end else begin
          load_error <= 1'b1;
        end
      end else if (enable) begin
        if (!underflow) begin
          count <= dec_value;
          done  <= (dec_value == '0);
        end else if (reload != '0) begin
          count <= reload;
        end
      end
    end
  end
`else
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count      <= '0;
      done       <= 1'b0;
      load_error <= 1'b0;
    end else begin
      done       <= 1'b0;
      load_error <= 1'b0;
      if (load) begin
        if (load_ok) count <= load_value;
        else         load_error <= 1'b1;
      end else if (enable && !underflow) begin
        count <= dec_value;
        done  <= (dec_value == '0);
      end
    end
  end
`endif

endmodule

// File: tb/tb_bcd_down_timer.sv
// Directed testbench for bcd_down_timer (2-digit and 3-digit instances).
module tb_bcd_down_timer;

  logic        clock;
  logic        reset;
  logic        load;
  logic [7:0]  load_value;
  logic        enable;
  logic [7:0]  count;
  logic        zero;
  logic        done;
  logic        load_error;

  logic        load3;
  logic [11:0] load_value3;
  logic        enable3;
  logic [11:0] count3;
  logic        zero3;
  logic        done3;
  logic        load_error3;

  int tests_run;
  int tests_failed;

  bcd_down_timer #(.DIGITS(2)) dut (
    .clock      (clock),
    .reset      (reset),
    .load       (load),
    .load_value (load_value),
    .enable     (enable),
    .count      (count),
    .zero       (zero),
    .done       (done),
    .load_error (load_error)
  );

  bcd_down_timer #(.DIGITS(3)) dut3 (
    .clock      (clock),
    .reset      (reset),
    .load       (load3),
    .load_value (load_value3),
    .enable     (enable3),
    .count      (count3),
    .zero       (zero3),
    .done       (done3),
    .load_error (load_error3)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_load(input logic [7:0] value);
    load       = 1'b1;
    load_value = value;
    step();
    load       = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #2;
    tests_run++;
    if (count !== 8'h00 || zero !== 1'b1 || done !== 1'b0 || load_error !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_state: count=%h zero=%b done=%b err=%b expected 00 1 0 0",
               count, zero, done, load_error);
    end
    step();
    reset = 1'b1;
    step();
    do_load(8'h37);
    tests_run++;
    if (count !== 8'h37) begin
      tests_failed++;
      $display("[TB] FAIL reset_preload: count=%h expected 37", count);
    end
    #2;
    reset = 1'b0;
    #1;
    tests_run++;
    if (count !== 8'h00 || zero !== 1'b1 || done !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_async: count=%h zero=%b done=%b expected 00 1 0",
               count, zero, done);
    end
    step();
    reset = 1'b1;
    step();
  endtask

  task automatic test_full_countdown();
    logic [7:0] expected;
    do_load(8'h25);
    tests_run++;
    if (count !== 8'h25 || zero !== 1'b0 || done !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL countdown_load: count=%h zero=%b done=%b expected 25 0 0",
               count, zero, done);
    end
    enable = 1'b1;
    for (int i = 1; i <= 25; i++) begin
      step();
      expected = 8'(((25 - i) / 10) * 16 + ((25 - i) % 10));
      tests_run++;
      if (count !== expected || done !== (i == 25) || zero !== (i == 25)) begin
        tests_failed++;
        $display("[TB] FAIL countdown_step%0d: count=%h done=%b zero=%b expected %h %b %b",
                 i, count, done, zero, expected, (i == 25), (i == 25));
      end
    end
    step();
`ifdef BCD_TIMER_AUTO_RELOAD_EN
    expected = 8'h25;
`else
    expected = 8'h00;
`endif
    tests_run++;
    if (count !== expected || done !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL countdown_after_zero: count=%h done=%b expected %h 0",
               count, done, expected);
    end
    enable = 1'b0;
    step();
  endtask

  task automatic test_borrow();
    do_load(8'h10);
    enable = 1'b1;
    step();
    enable = 1'b0;
    tests_run++;
    if (count !== 8'h09 || done !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL borrow_10: count=%h done=%b expected 09 0", count, done);
    end
    load3       = 1'b1;
    load_value3 = 12'h100;
    step();
    load3   = 1'b0;
    enable3 = 1'b1;
    step();
    enable3 = 1'b0;
    tests_run++;
    if (count3 !== 12'h099 || done3 !== 1'b0 || zero3 !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL borrow_100: count=%h done=%b zero=%b expected 099 0 0",
               count3, done3, zero3);
    end
    load3       = 1'b1;
    load_value3 = 12'h001;
    step();
    load3   = 1'b0;
    enable3 = 1'b1;
    step();
    enable3 = 1'b0;
    tests_run++;
    if (count3 !== 12'h000 || done3 !== 1'b1 || zero3 !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL done_3digit: count=%h done=%b zero=%b expected 000 1 1",
               count3, done3, zero3);
    end
  endtask

  task automatic test_invalid_load();
    do_load(8'h42);
    do_load(8'h3A);
    tests_run++;
    if (load_error !== 1'b1 || count !== 8'h42) begin
      tests_failed++;
      $display("[TB] FAIL invalid_low: err=%b count=%h expected 1 42", load_error, count);
    end
    step();
    tests_run++;
    if (load_error !== 1'b0 || count !== 8'h42) begin
      tests_failed++;
      $display("[TB] FAIL invalid_pulse_end: err=%b count=%h expected 0 42", load_error, count);
    end
    do_load(8'hA0);
    tests_run++;
    if (load_error !== 1'b1 || count !== 8'h42) begin
      tests_failed++;
      $display("[TB] FAIL invalid_high: err=%b count=%h expected 1 42", load_error, count);
    end
    do_load(8'h39);
    tests_run++;
    if (load_error !== 1'b0 || count !== 8'h39) begin
      tests_failed++;
      $display("[TB] FAIL valid_after_invalid: err=%b count=%h expected 0 39", load_error, count);
    end
  endtask

  task automatic test_simultaneous();
    do_load(8'h01);
    load       = 1'b1;
    load_value = 8'h07;
    enable     = 1'b1;
    step();
    load   = 1'b0;
    enable = 1'b0;
    tests_run++;
    if (count !== 8'h07 || done !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL load_priority: count=%h done=%b expected 07 0", count, done);
    end
    do_load(8'h00);
    tests_run++;
    if (count !== 8'h00 || zero !== 1'b1 || done !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL load_zero: count=%h zero=%b done=%b expected 00 1 0",
               count, zero, done);
    end
  endtask

`ifdef BCD_TIMER_AUTO_RELOAD_EN
  task automatic test_auto_reload();
    logic [7:0] seq [8];
    logic       pulse [8];
    seq   = '{8'h02, 8'h01, 8'h00, 8'h03, 8'h02, 8'h01, 8'h00, 8'h03};
    pulse = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    do_load(8'h03);
    enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      tests_run++;
      if (count !== seq[i] || done !== pulse[i]) begin
        tests_failed++;
        $display("[TB] FAIL auto_reload_%0d: count=%h done=%b expected %h %b",
                 i, count, done, seq[i], pulse[i]);
      end
    end
    enable = 1'b0;
  endtask
`else
  task automatic test_hold_at_zero();
    do_load(8'h01);
    enable = 1'b1;
    step();
    tests_run++;
    if (count !== 8'h00 || done !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL hold_reach: count=%h done=%b expected 00 1", count, done);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      tests_run++;
      if (count !== 8'h00 || done !== 1'b0 || zero !== 1'b1) begin
        tests_failed++;
        $display("[TB] FAIL hold_%0d: count=%h done=%b zero=%b expected 00 0 1",
                 i, count, done, zero);
      end
    end
    enable = 1'b0;
  endtask
`endif

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    load         = 1'b0;
    load_value   = 8'h00;
    enable       = 1'b0;
    load3        = 1'b0;
    load_value3  = 12'h000;
    enable3      = 1'b0;
    test_reset();
    test_full_countdown();
    test_borrow();
    test_invalid_load();
    test_simultaneous();
`ifdef BCD_TIMER_AUTO_RELOAD_EN
    test_auto_reload();
`else
    test_hold_at_zero();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
